// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs opcode, register, funct and immediate fields
// into a 32-bit word over a two-stage elastic pipeline, flagging out-of-range immediates.
module instr_encoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_in_ready,
  input  logic [2:0]           i_fmt,
  input  logic [6:0]           i_opcode,
  input  logic [4:0]           i_rd,
  input  logic [4:0]           i_rs1,
  input  logic [4:0]           i_rs2,
  input  logic [2:0]           i_funct3,
  input  logic [6:0]           i_funct7,
  input  logic [31:0]          i_imm,
  output logic                 o_valid,
  input  logic                 i_out_ready,
  output logic [31:0]          o_instr,
  output logic                 o_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  function automatic logic imm_err(input logic [2:0] fmt, input logic signed [31:0] imm);
    logic e;
    e = 1'b0;
    case (fmt)
      FMT_R:        e = 1'b0;
      FMT_I, FMT_S: e = (imm < -32'sd2048) || (imm > 32'sd2047);
      FMT_B:        e = (imm < -32'sd4096) || (imm > 32'sd4094) || imm[0];
      FMT_U:        e = (imm[11:0] != 12'h000);
      FMT_J:        e = (imm < -32'sd1048576) || (imm > 32'sd1048574) || imm[0];
      default:      e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] pack(input logic [2:0] fmt, input logic [6:0] opcode,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [2:0] funct3,
                                       input logic [6:0] funct7, input logic signed [31:0] imm);
    logic [31:0] w;
    w = 32'h0;
    w[6:0] = opcode;
    case (fmt)
      FMT_R: begin
        w[11:7]  = rd;
        w[14:12] = funct3;
        w[19:15] = rs1;
        w[24:20] = rs2;
        w[31:25] = funct7;
      end
      FMT_I: begin
        w[11:7]  = rd;
        w[14:12] = funct3;
        w[19:15] = rs1;
        w[31:20] = imm[11:0];
      end
      FMT_S: begin
        w[11:7]  = imm[4:0];
        w[14:12] = funct3;
        w[19:15] = rs1;
        w[24:20] = rs2;
        w[31:25] = imm[11:5];
      end
      FMT_B: begin
        w[7]     = imm[11];
        w[11:8]  = imm[4:1];
        w[14:12] = funct3;
        w[19:15] = rs1;
        w[24:20] = rs2;
        w[30:25] = imm[10:5];
        w[31]    = imm[12];
      end
      FMT_U: begin
        w[11:7]  = rd;
        w[31:12] = imm[31:12];
      end
      FMT_J: begin
        w[11:7]  = rd;
        w[19:12] = imm[19:12];
        w[20]    = imm[11];
        w[30:21] = imm[10:1];
        w[31]    = imm[20];
      end
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
    return (&c) ? c : c + ERR_CNT_W'(1);
  endfunction

  logic                 vld_p1, vld_p2;
  logic                 err_p1, err_p2;
  logic [2:0]           fmt_p1;
  logic [6:0]           opcode_p1;
  logic [4:0]           rd_p1, rs1_p1, rs2_p1;
  logic [2:0]           funct3_p1;
  logic [6:0]           funct7_p1;
  logic signed [31:0]   imm_p1;
  logic [31:0]          instr_p2;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 s1_adv, s2_adv;

  assign s2_adv     = ~vld_p2 | i_out_ready;
  assign s1_adv     = ~vld_p1 | s2_adv;
  assign o_in_ready = s1_adv;

  // Stage 1: capture request fields and range-check result
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
    end else if (s1_adv) begin
      vld_p1 <= i_valid;
      err_p1 <= imm_err(i_fmt, i_imm);
    end
  end

  always_ff @(posedge i_clk) begin
    if (s1_adv) begin
      fmt_p1    <= i_fmt;
      opcode_p1 <= i_opcode;
      rd_p1     <= i_rd;
      rs1_p1    <= i_rs1;
      rs2_p1    <= i_rs2;
      funct3_p1 <= i_funct3;
      funct7_p1 <= i_funct7;
      imm_p1    <= i_imm;
    end
  end

  // Stage 2: packed word, zeroed on error; held while downstream stalls
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_p2   <= 1'b0;
      err_p2   <= 1'b0;
      instr_p2 <= 32'h0;
    end else if (s2_adv) begin
      vld_p2   <= vld_p1;
      err_p2   <= err_p1;
      instr_p2 <= err_p1 ? 32'h0 : pack(fmt_p1, opcode_p1, rd_p1, rs1_p1, rs2_p1,
                                        funct3_p1, funct7_p1, imm_p1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_cnt <= '0;
    end else if (vld_p2 && i_out_ready && err_p2) begin
      err_cnt <= sat_inc(err_cnt);
    end
  end

  assign o_valid   = vld_p2;
  assign o_instr   = instr_p2;
  assign o_err     = err_p2;
  assign o_err_cnt = err_cnt;

endmodule
